// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one single-port memory bus between instruction fetch and data memory.
// Grants are held stable until slave ack or a bounded-wait timeout aborts the cycle.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ack_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ack_o,
  output logic              bus_cyc_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              stallreq_o,
  output logic              bus_err_o
);

  typedef enum logic [1:0] {IDLE, GRANT_D, GRANT_I} state_t;
  typedef enum logic {FETCH, DATA} grant_t;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  state_t     r_state;
  grant_t     r_last;
  logic [7:0] r_cnt;

  logic w_if_req;
  logic w_mem_req;
  logic w_pick_data;

  // Requesters may hold req high during their ack cycle; mask it there.
  assign w_if_req    = if_req_i & ~if_ack_o;
  assign w_mem_req   = mem_req_i & ~mem_ack_o;
  assign w_pick_data = w_mem_req & ~(w_if_req & (r_last == DATA));
  assign stallreq_o  = ~rst & (w_if_req | w_mem_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last      <= FETCH;
      r_cnt       <= '0;
      if_data_o   <= '0;
      if_ack_o    <= 1'b0;
      mem_rdata_o <= '0;
      mem_ack_o   <= 1'b0;
      bus_cyc_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_sel_o   <= '0;
      bus_wdata_o <= '0;
      bus_err_o   <= 1'b0;
    end else begin
      if_ack_o  <= 1'b0;
      mem_ack_o <= 1'b0;
      bus_err_o <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_pick_data) begin
            r_state     <= GRANT_D;
            r_last      <= DATA;
            bus_cyc_o   <= 1'b1;
            bus_we_o    <= mem_we_i;
            bus_addr_o  <= mem_addr_i;
            bus_sel_o   <= mem_sel_i;
            bus_wdata_o <= mem_wdata_i;
          end else if (w_if_req) begin
            r_state    <= GRANT_I;
            r_last     <= FETCH;
            bus_cyc_o  <= 1'b1;
            bus_we_o   <= 1'b0;
            bus_addr_o <= if_addr_i;
            bus_sel_o  <= 4'b1111;
          end
        end
        GRANT_D, GRANT_I: begin
          // A real ack on the limit cycle wins over the timeout.
          if (bus_ack_i || (r_cnt == LIMIT)) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            bus_cyc_o <= 1'b0;
            bus_err_o <= ~bus_ack_i;
            if (r_state == GRANT_I) begin
              if_ack_o  <= 1'b1;
              if_data_o <= bus_ack_i ? bus_rdata_i : '0;
            end else begin
              mem_ack_o <= 1'b1;
              if (!bus_we_o) mem_rdata_o <= bus_ack_i ? bus_rdata_i : '0;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
